// File: rtl/bilinear_interp_core_mc.sv
// Four-stage bilinear interpolator, CHANNELS colour channels sharing one set of X/Y weights.
// Define BI_INTERP_ROUND_EN for round-half-up; otherwise results are floored. Both builds clamp.
module bilinear_interp_core_mc #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SCALE_FW = 8,
  parameter int unsigned USER_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*DATA_W-1:0]   i_pix_00,
  input  logic [CHANNELS*DATA_W-1:0]   i_pix_01,
  input  logic [CHANNELS*DATA_W-1:0]   i_pix_10,
  input  logic [CHANNELS*DATA_W-1:0]   i_pix_11,
  input  logic [SCALE_FW-1:0]          i_offset_x,
  input  logic [SCALE_FW-1:0]          i_offset_y,
  input  logic [USER_W-1:0]            i_user,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [CHANNELS*DATA_W-1:0]   o_pix,
  output logic [USER_W-1:0]            o_user
);

  localparam int unsigned PW = CHANNELS * DATA_W;
  localparam int unsigned WW = SCALE_FW + 1;
  localparam int unsigned LW = DATA_W + SCALE_FW + 1;
  localparam int unsigned AW = DATA_W + 2 * SCALE_FW + 2;
  localparam logic [WW-1:0] One    = WW'(1) << SCALE_FW;
  localparam logic [AW:0]   MaxPix = (AW + 1)'((2 ** DATA_W) - 1);
`ifdef BI_INTERP_ROUND_EN
  localparam logic [AW:0]   RoundK = (AW + 1)'(1) << (2 * SCALE_FW - 1);
`else
  localparam logic [AW:0]   RoundK = '0;
`endif

  logic advance;

  logic                          s1_valid_q, s1_valid_d;
  logic [PW-1:0]                 s1_p00_q, s1_p00_d, s1_p01_q, s1_p01_d;
  logic [PW-1:0]                 s1_p10_q, s1_p10_d, s1_p11_q, s1_p11_d;
  logic [WW-1:0]                 s1_wx0_q, s1_wx0_d, s1_wx1_q, s1_wx1_d;
  logic [WW-1:0]                 s1_wy0_q, s1_wy0_d, s1_wy1_q, s1_wy1_d;
  logic [USER_W-1:0]             s1_user_q, s1_user_d;

  logic                          s2_valid_q, s2_valid_d;
  logic [CHANNELS-1:0][LW-1:0]   s2_line0_q, s2_line0_d, s2_line1_q, s2_line1_d;
  logic [WW-1:0]                 s2_wy0_q, s2_wy0_d, s2_wy1_q, s2_wy1_d;
  logic [USER_W-1:0]             s2_user_q, s2_user_d;

  logic                          s3_valid_q, s3_valid_d;
  logic [CHANNELS-1:0][AW-1:0]   s3_acc_q, s3_acc_d;
  logic [USER_W-1:0]             s3_user_q, s3_user_d;

  logic                          s4_valid_q, s4_valid_d;
  logic [PW-1:0]                 s4_pix_q, s4_pix_d;
  logic [USER_W-1:0]             s4_user_q, s4_user_d;

  logic [AW:0]                   rsum, rshift;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  always_comb begin
    advance = i_ready | ~s4_valid_q;
    o_ready = advance;
    o_valid = s4_valid_q;
    o_pix   = s4_pix_q;
    o_user  = s4_user_q;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;  s1_user_d = s1_user_q;
    s1_p00_d   = s1_p00_q;    s1_p01_d  = s1_p01_q;
    s1_p10_d   = s1_p10_q;    s1_p11_d  = s1_p11_q;
    s1_wx0_d   = s1_wx0_q;    s1_wx1_d  = s1_wx1_q;
    s1_wy0_d   = s1_wy0_q;    s1_wy1_d  = s1_wy1_q;
    s2_valid_d = s2_valid_q;  s2_user_d = s2_user_q;
    s2_line0_d = s2_line0_q;  s2_line1_d = s2_line1_q;
    s2_wy0_d   = s2_wy0_q;    s2_wy1_d  = s2_wy1_q;
    s3_valid_d = s3_valid_q;  s3_user_d = s3_user_q;
    s3_acc_d   = s3_acc_q;
    s4_valid_d = s4_valid_q;  s4_user_d = s4_user_q;
    s4_pix_d   = s4_pix_q;
    rsum       = '0;
    rshift     = '0;
    if (advance) begin
      s1_valid_d = i_valid;
      s1_user_d  = i_user;
      s1_p00_d   = i_pix_00;
      s1_p01_d   = i_pix_01;
      s1_p10_d   = i_pix_10;
      s1_p11_d   = i_pix_11;
      s1_wx1_d   = WW'(i_offset_x);
      s1_wx0_d   = One - WW'(i_offset_x);
      s1_wy1_d   = WW'(i_offset_y);
      s1_wy0_d   = One - WW'(i_offset_y);

      s2_valid_d = s1_valid_q;
      s2_user_d  = s1_user_q;
      s2_wy0_d   = s1_wy0_q;
      s2_wy1_d   = s1_wy1_q;
      s3_valid_d = s2_valid_q;
      s3_user_d  = s2_user_q;
      s4_valid_d = s3_valid_q;
      s4_user_d  = s3_user_q;
      for (int c = 0; c < CHANNELS; c++) begin
        s2_line0_d[c] = LW'(s1_p00_q[c*DATA_W +: DATA_W]) * LW'(s1_wx0_q)
                      + LW'(s1_p01_q[c*DATA_W +: DATA_W]) * LW'(s1_wx1_q);
        s2_line1_d[c] = LW'(s1_p10_q[c*DATA_W +: DATA_W]) * LW'(s1_wx0_q)
                      + LW'(s1_p11_q[c*DATA_W +: DATA_W]) * LW'(s1_wx1_q);
        s3_acc_d[c]   = AW'(s2_line0_q[c]) * AW'(s2_wy0_q)
                      + AW'(s2_line1_q[c]) * AW'(s2_wy1_q);
        rsum          = {1'b0, s3_acc_q[c]} + RoundK;
        rshift        = rsum >> (2 * SCALE_FW);
        s4_pix_d[c*DATA_W +: DATA_W] = (rshift > MaxPix) ? {DATA_W{1'b1}}
                                                         : rshift[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;  s1_user_q <= '0;
      s1_p00_q   <= '0;    s1_p01_q  <= '0;
      s1_p10_q   <= '0;    s1_p11_q  <= '0;
      s1_wx0_q   <= '0;    s1_wx1_q  <= '0;
      s1_wy0_q   <= '0;    s1_wy1_q  <= '0;
      s2_valid_q <= 1'b0;  s2_user_q <= '0;
      s2_line0_q <= '0;    s2_line1_q <= '0;
      s2_wy0_q   <= '0;    s2_wy1_q  <= '0;
      s3_valid_q <= 1'b0;  s3_user_q <= '0;
      s3_acc_q   <= '0;
      s4_valid_q <= 1'b0;  s4_user_q <= '0;
      s4_pix_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;  s1_user_q <= s1_user_d;
      s1_p00_q   <= s1_p00_d;    s1_p01_q  <= s1_p01_d;
      s1_p10_q   <= s1_p10_d;    s1_p11_q  <= s1_p11_d;
      s1_wx0_q   <= s1_wx0_d;    s1_wx1_q  <= s1_wx1_d;
      s1_wy0_q   <= s1_wy0_d;    s1_wy1_q  <= s1_wy1_d;
      s2_valid_q <= s2_valid_d;  s2_user_q <= s2_user_d;
      s2_line0_q <= s2_line0_d;  s2_line1_q <= s2_line1_d;
      s2_wy0_q   <= s2_wy0_d;    s2_wy1_q  <= s2_wy1_d;
      s3_valid_q <= s3_valid_d;  s3_user_q <= s3_user_d;
      s3_acc_q   <= s3_acc_d;
      s4_valid_q <= s4_valid_d;  s4_user_q <= s4_user_d;
      s4_pix_q   <= s4_pix_d;
    end
  end

endmodule

// File: tb/tb_bilinear_interp_core_mc.sv
// Scoreboard bench for bilinear_interp_core_mc; honours BI_INTERP_ROUND_EN like the design.
module tb_bilinear_interp_core_mc;

  localparam int CH = 3;
  localparam int DW = 8;
  localparam int FW = 8;
  localparam int UW = 2;
  localparam int PW = CH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] i_pix_00, i_pix_01, i_pix_10, i_pix_11;
  logic [FW-1:0] i_offset_x, i_offset_y;
  logic [UW-1:0] i_user;
  logic          i_valid, o_ready, o_valid, i_ready;
  logic [PW-1:0] o_pix;
  logic [UW-1:0] o_user;

  typedef struct packed {
    logic [PW-1:0] pix;
    logic [UW-1:0] user;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   passed   = 0;
  int   total    = 0;
  int   rx_count = 0;

  bilinear_interp_core_mc #(
    .CHANNELS(CH), .DATA_W(DW), .SCALE_FW(FW), .USER_W(UW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_pix_00(i_pix_00), .i_pix_01(i_pix_01), .i_pix_10(i_pix_10), .i_pix_11(i_pix_11),
    .i_offset_x(i_offset_x), .i_offset_y(i_offset_y), .i_user(i_user),
    .i_valid(i_valid), .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_pix(o_pix), .o_user(o_user)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] model(input logic [PW-1:0] p00, p01, p10, p11,
                                          input logic [FW-1:0] ox, oy);
    logic [PW-1:0] r;
    longint wx1, wx0, wy1, wy0, acc, res;
    r   = '0;
    wx1 = longint'(ox);  wx0 = 256 - wx1;
    wy1 = longint'(oy);  wy0 = 256 - wy1;
    for (int c = 0; c < CH; c++) begin
      acc = (longint'(p00[c*DW +: DW]) * wx0 + longint'(p01[c*DW +: DW]) * wx1) * wy0
          + (longint'(p10[c*DW +: DW]) * wx0 + longint'(p11[c*DW +: DW]) * wx1) * wy1;
`ifdef BI_INTERP_ROUND_EN
      acc = acc + 32768;
`endif
      res = acc / 65536;
      if (res > 255) res = 255;
      r[c*DW +: DW] = res[DW-1:0];
    end
    return r;
  endfunction

  // Output side: every handshaken beat is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_beat: got pix=%h user=%h, required no beat", o_pix, o_user);
      end else begin
        e = sb_q.pop_front();
        rx_count++;
        if (o_pix !== e.pix || o_user !== e.user)
          $display("FAIL out_beat: got pix=%h user=%h, required pix=%h user=%h",
                   o_pix, o_user, e.pix, e.user);
        else passed++;
      end
    end
  end

  // Starts and ends on a negedge; input is held until o_ready is seen.
  task automatic send(input logic [PW-1:0] p00, p01, p10, p11, input logic [FW-1:0] ox, oy,
                      input logic [UW-1:0] u, input logic [PW-1:0] exp_pix);
    i_pix_00 = p00; i_pix_01 = p01; i_pix_10 = p10; i_pix_11 = p11;
    i_offset_x = ox; i_offset_y = oy; i_user = u; i_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (o_ready) begin
        sb_q.push_back('{pix: exp_pix, user: u});
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    total++;
    $display("FAIL send_timeout: o_ready stayed 0 for 50 cycles, required 1");
    i_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!o_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_pix_00 = '0; i_pix_01 = '0; i_pix_10 = '0; i_pix_11 = '0;
    i_offset_x = '0; i_offset_y = '0; i_user = '0;
    repeat (3) @(negedge clk);
    total++;
    if (o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b, required 0", o_valid);
    else passed++;
    total++;
    if (o_pix !== '0) $display("FAIL reset_o_pix: got %h, required 0", o_pix);
    else passed++;
    total++;
    if (o_user !== '0) $display("FAIL reset_o_user: got %h, required 0", o_user);
    else passed++;
    total++;
    if (o_ready !== 1'b1) $display("FAIL reset_o_ready: got %b, required 1", o_ready);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int lat;
    send({3{8'd200}}, {3{8'd17}}, {3{8'd99}}, {3{8'd3}}, 8'd0, 8'd0, 2'd1, {3{8'd200}});
    wait_out(lat);
    total++;
    if (lat !== 4) $display("FAIL identity_latency: got %0d, required 4", lat);
    else passed++;
  endtask

  task automatic test_center();
    int lat;
    send({3{8'd10}}, {3{8'd20}}, {3{8'd30}}, {3{8'd40}}, 8'd128, 8'd128, 2'd2, {3{8'd25}});
    wait_out(lat);
    total++;
    if (lat !== 4) $display("FAIL center_latency: got %0d, required 4", lat);
    else passed++;
  endtask

  task automatic test_round();
    int lat;
    logic [PW-1:0] ex;
`ifdef BI_INTERP_ROUND_EN
    ex = {3{8'd11}};
`else
    ex = {3{8'd10}};
`endif
    send({3{8'd10}}, {3{8'd11}}, {3{8'd0}}, {3{8'd0}}, 8'd128, 8'd0, 2'd3, ex);
    wait_out(lat);
    total++;
    if (lat !== 4) $display("FAIL round_latency: got %0d, required 4", lat);
    else passed++;
  endtask

  task automatic test_saturate();
    int lat;
    send({3{8'd255}}, {3{8'd255}}, {3{8'd255}}, {3{8'd255}}, 8'd255, 8'd255, 2'd0,
         {3{8'd255}});
    wait_out(lat);
    total++;
    if (lat !== 4) $display("FAIL saturate_latency: got %0d, required 4", lat);
    else passed++;
  endtask

  task automatic test_linear();
    int lat;
    logic [PW-1:0] a, b;
    a = {8'd0, 8'd100, 8'd60};
    b = {8'd255, 8'd200, 8'd20};
    // y-only interpolation on one beat, x-only on the next
    send(a, {3{8'd7}}, b, {3{8'd9}}, 8'd0, 8'd64, 2'd1, model(a, {3{8'd7}}, b, {3{8'd9}},
         8'd0, 8'd64));
    send(a, b, {3{8'd5}}, {3{8'd6}}, 8'd192, 8'd0, 2'd2, model(a, b, {3{8'd5}}, {3{8'd6}},
         8'd192, 8'd0));
    wait_out(lat);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int start_rx;
    int n;
    start_rx = rx_count;
    fork
      begin
        logic [PW-1:0] p0, p1, p2, p3;
        logic [FW-1:0] ox, oy;
        for (int i = 0; i < 8; i++) begin
          p0 = PW'($urandom); p1 = PW'($urandom); p2 = PW'($urandom); p3 = PW'($urandom);
          ox = FW'($urandom); oy = FW'($urandom);
          send(p0, p1, p2, p3, ox, oy, UW'(i), model(p0, p1, p2, p3, ox, oy));
          i_valid = 1'b1;
        end
        i_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          total++;
          if (sb_q.size() == 0)
            $display("FAIL stall_hold: scoreboard empty during stall, required pending beat");
          else if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_pix !== sb_q[0].pix ||
                   o_user !== sb_q[0].user)
            $display("FAIL stall_hold: got rdy=%b vld=%b pix=%h user=%h, required 0 1 %h %h",
                     o_ready, o_valid, o_pix, o_user, sb_q[0].pix, sb_q[0].user);
          else passed++;
          @(posedge clk);
        end
        #1 i_ready = 1'b1;
      end
    join
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rx_count - start_rx !== 8)
      $display("FAIL b2b_count: got %0d beats, required 8", rx_count - start_rx);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    int lat;
    int stale;
    for (int i = 0; i < 3; i++) begin
      send({3{8'd50}}, {3{8'd60}}, {3{8'd70}}, {3{8'd80}}, 8'd32, 8'd96, UW'(i),
           model({3{8'd50}}, {3{8'd60}}, {3{8'd70}}, {3{8'd80}}, 8'd32, 8'd96));
      i_valid = 1'b1;
    end
    i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    sb_q.delete();
    total++;
    if (o_valid !== 1'b0) $display("FAIL midrst_o_valid: got %b, required 0", o_valid);
    else passed++;
    rst = 1'b0;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_valid) stale++;
    end
    total++;
    if (stale !== 0) $display("FAIL midrst_stale: got %0d stale cycles, required 0", stale);
    else passed++;
    send({3{8'd1}}, {3{8'd201}}, {3{8'd1}}, {3{8'd201}}, 8'd128, 8'd77, 2'd3,
         model({3{8'd1}}, {3{8'd201}}, {3{8'd1}}, {3{8'd201}}, 8'd128, 8'd77));
    wait_out(lat);
    total++;
    if (lat !== 4) $display("FAIL midrst_latency: got %0d, required 4", lat);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_center();
    test_round();
    test_saturate();
    test_linear();
    test_back_to_back();
    test_reset_midstream();
    repeat (6) @(negedge clk);
    total++;
    if (sb_q.size() != 0) $display("FAIL drain: %0d beats outstanding, required 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bilinear_interp_core_mc.md
BILINEAR_INTERP_CORE_MC -- requirements
Module: bilinear_interp_core_mc

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 3, meaning the number of colour channels processed in parallel, with shared weights.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the bits per channel sample.
REQ-003 The block SHALL have parameter SCALE_FW, default 8, meaning the fractional bits of the X/Y offsets.
REQ-004 The block SHALL have parameter USER_W, default 2, meaning the width of the sideband field carried alongside each pixel.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have ports i_pix_00, i_pix_01, i_pix_10 and i_pix_11, inputs, CHANNELS*DATA_W bits each: the neighbour samples, with channel c at bits [c*DATA_W +: DATA_W].
REQ-008 The block SHALL have ports i_offset_x and i_offset_y, inputs, SCALE_FW bits each: the fractional position in the range 0..2^SCALE_FW-1.
REQ-009 The block SHALL have port i_user, input, USER_W bits: sideband data (e.g. sof/eol), passed through unchanged.
REQ-010 The block SHALL have port i_valid, input, 1 bit, and port o_ready, output, 1 bit: the input handshake.
REQ-011 The block SHALL have port o_valid, output, 1 bit, and port i_ready, input, 1 bit: the output handshake.
REQ-012 The block SHALL have port o_pix, output, CHANNELS*DATA_W bits, using the same channel packing as the inputs; and port o_user, output, USER_W bits.

Function
REQ-013 The block SHALL compute weights wx1=i_offset_x and wx0=2^SCALE_FW-i_offset_x, each SCALE_FW+1 bits unsigned; wy0 and wy1 SHALL be computed the same way from i_offset_y.
REQ-014 The block SHALL compute, per channel, line0=p00*wx0+p01*wx1 and line1=p10*wx0+p11*wx1, each DATA_W+SCALE_FW+1 bits, with no truncation.
REQ-015 The block SHALL compute, per channel, acc=line0*wy0+line1*wy1, DATA_W+2*SCALE_FW+2 bits, with no truncation.
REQ-016 Each channel result SHALL be acc>>2*SCALE_FW, post-processed per REQ-029/REQ-030 and clamped to 2^DATA_W-1.
REQ-017 The block SHALL be a 4-stage pipeline: S1 registers inputs and weights, S2 registers line0/line1 and the delayed Y weights, S3 registers acc, and S4 is the output register.
REQ-018 i_offset_y and i_user SHALL travel with their own beat; beats SHALL never mix across stages.
REQ-019 advance SHALL equal i_ready OR NOT o_valid; all stages SHALL shift only when advance is 1; per-stage valid bits SHALL move with the data.
REQ-020 o_ready SHALL equal advance and SHALL be purely combinational from i_ready and o_valid.
REQ-021 An input beat SHALL be accepted when i_valid=1 and o_ready=1.
REQ-022 Latency with i_ready held 1 SHALL be 4 cycles from acceptance to o_valid=1; throughput SHALL be 1 beat per clock.
REQ-023 While i_ready=0 and o_valid=1, o_pix, o_user and o_valid SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-024 Beats SHALL emerge in acceptance order.
REQ-025 o_pix SHALL equal p00 exactly when the offset is 0/0; with offset 0 in one axis, the other axis SHALL reduce to linear interpolation.

Reset
REQ-026 While rst=1, all stage valid bits and o_valid SHALL be 0 on the next clock edge; o_pix and o_user SHALL be 0.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight beats; none SHALL appear after rst is released.
REQ-028 The first beat accepted after rst is released SHALL appear after the normal 4-cycle latency.

Configuration
REQ-029 With BI_INTERP_ROUND_EN defined, the block SHALL add 2^(2*SCALE_FW-1) to acc before the shift (round half up), followed by the saturating clamp.
REQ-030 Without BI_INTERP_ROUND_EN, the block SHALL truncate (floor) with the clamp still present, and latency and handshakes SHALL be identical in both builds.

Verification
(All scenarios use default parameters, with i_ready=1 unless stated.)
REQ-031 A bench SHALL cover: p00=200 on all channels, offsets 0/0 -> o_pix channels = 200, 4 cycles after acceptance.
REQ-032 A bench SHALL cover: p=10,20,30,40, offsets 128/128 -> 25 on every channel in both builds.
REQ-033 A bench SHALL cover: p00=10, p01=11, x=128, y=0 -> 11 with BI_INTERP_ROUND_EN and 10 without it.
REQ-034 A bench SHALL cover: all samples 255, offsets 255/255 -> 255 with no wrap, in both builds.
REQ-035 A bench SHALL cover: 8 back-to-back beats with i_ready=0 for 3 cycles mid-burst -> o_ready=0 while stalled, outputs held, all 8 results in order, and o_user matching.
REQ-036 A bench SHALL cover: rst pulsed for 1 cycle with 3 beats in flight -> o_valid=0 next cycle, no stale beats, and the next beat emerging at latency 4.
